// File: rtl/univ_shift_register.sv
// N-bit universal shift register: hold, shift left, shift right, parallel load.
// Optional registered even-parity output when SHIFT_REGISTER_PARITY_EN is defined.
module univ_shift_register #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   ctrl,
  input  logic [N-1:0] data,
  output logic [N-1:0] q_reg
`ifdef SHIFT_REGISTER_PARITY_EN
  ,
  output logic         q_parity
`endif
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHL   = 2'b01;
  localparam logic [1:0] MODE_SHR   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [N-1:0] r_q;
  logic [N-1:0] w_next;

`ifdef SHIFT_REGISTER_PARITY_EN
  logic r_parity;

  function automatic logic calc_parity(input logic [N-1:0] v);
    return ^v;
  endfunction
`endif

  // Next-state selection; only the serial-in bit of data matters when shifting
  always_comb begin
    w_next = r_q;
    case (ctrl)
      MODE_HOLD: w_next = r_q;
      MODE_SHL:  w_next = {r_q[N-2:0], data[0]};
      MODE_SHR:  w_next = {data[N-1], r_q[N-1:1]};
      MODE_LOAD: w_next = data;
      default:   w_next = r_q;
    endcase
  end

  // State register with immediate clear on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= {N{1'b0}};
    end else begin
      r_q <= w_next;
    end
  end

`ifdef SHIFT_REGISTER_PARITY_EN
  // Parity is computed from the next state so it lands on the same edge as r_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= calc_parity(w_next);
    end
  end

  assign q_parity = r_parity;
`endif

  assign q_reg = r_q;

endmodule

// File: tb/tb_univ_shift_register.sv
// Scoreboard bench for univ_shift_register (N=8): stimulus pushes expected
// values into a queue, a monitor pops and compares on falling-edge samples.
module tb_univ_shift_register;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] data = 8'h00;
  logic [7:0] q_reg;
`ifdef SHIFT_REGISTER_PARITY_EN
  logic       q_parity;
`endif

  univ_shift_register #(.N(8)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl),
    .data  (data),
    .q_reg (q_reg)
`ifdef SHIFT_REGISTER_PARITY_EN
    ,
    .q_parity (q_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry whose due edge has passed
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        checks++;
        if (q_reg !== e.val) begin
          failures++;
          $display("FAIL q_reg cyc=%0d actual=%h expected=%h", cyc, q_reg, e.val);
        end
`ifdef SHIFT_REGISTER_PARITY_EN
        checks++;
        if (q_parity !== (^e.val)) begin
          failures++;
          $display("FAIL q_parity cyc=%0d actual=%b expected=%b", cyc, q_parity, ^e.val);
        end
`endif
      end
    end
  end

  task automatic push_exp(input logic [7:0] v, input int due);
    exp_t e;
    e.val = v;
    e.due = due;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [1:0] c, input logic [7:0] d,
                      input logic [7:0] expv);
    @(negedge clk);
    reset = rst;
    ctrl  = c;
    data  = d;
    push_exp(expv, cyc + 1);
  endtask

  logic [7:0] shl_tab [8] = '{8'h46, 8'h8C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h80, 8'h00};
  logic [7:0] shr_tab [8] = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

  initial begin
    logic [7:0] d;

    // Reset held 20 cycles with arbitrary controls
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'($urandom_range(3, 0)), 8'($urandom_range(255, 0)), 8'h00);
    end
    step(1'b0, 2'b00, 8'h00, 8'h00);

    // Hold from zero ignores data
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 8'h55, 8'h00);

    // Random parallel loads, each held for two cycles
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom_range(255, 0));
      step(1'b0, 2'b11, d, d);
      step(1'b0, 2'b11, d, d);
    end

    // Load then hold a nonzero value
    step(1'b0, 2'b11, 8'hA3, 8'hA3);
    step(1'b0, 2'b00, 8'h5A, 8'hA3);
    step(1'b0, 2'b00, 8'hFF, 8'hA3);

    // Shift left 8 times with serial-in 0
    for (int i = 0; i < 8; i++) step(1'b0, 2'b01, 8'hAA, shl_tab[i]);

    // Shift left with serial-in 1 from zero, other data bits ignored
    step(1'b0, 2'b01, 8'h01, 8'h01);
    step(1'b0, 2'b01, 8'h81, 8'h03);

    // Shift right 8 times with serial-in 0 from all ones
    step(1'b0, 2'b11, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) step(1'b0, 2'b10, 8'h0F, shr_tab[i]);

    // Shift right with serial-in 1 from zero
    step(1'b0, 2'b10, 8'h80, 8'h80);
    step(1'b0, 2'b10, 8'h80, 8'hC0);
    step(1'b0, 2'b10, 8'h80, 8'hE0);

    // Asynchronous reset between edges while still shifting
    @(negedge clk);
    #3;
    reset = 1'b1;
    push_exp(8'h00, cyc);
    step(1'b1, 2'b10, 8'h80, 8'h00);
    step(1'b0, 2'b00, 8'h80, 8'h00);
    step(1'b0, 2'b10, 8'h80, 8'h80);

    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
